sound_event_sequencer: RTL and testbench

SOUND_EVENT_SEQUENCER -- requirements
Module: sound_event_sequencer

---
 rtl/sound_event_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sound_event_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_sequencer.sv
// Sound event sequencer: queues game sound events and plays them one at a time
// as a trigger strobe plus held code, separated by a silent gap.
module sound_event_sequencer #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned DUR_EAT       = CLK_FREQ / 10,
    parameter int unsigned DUR_GAME_OVER = CLK_FREQ,
    parameter int unsigned DUR_START     = CLK_FREQ / 2,
    parameter int unsigned GAP_CYCLES    = CLK_FREQ / 100,
    parameter int unsigned DEPTH         = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       evt_eat,
    input  logic       evt_game_over,
    input  logic       evt_start,
    input  logic       mute,
    output logic [1:0] sound_event_code_out,
    output logic       sound_trigger_out,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] CODE_NONE      = 2'b00;
    localparam logic [1:0] CODE_EAT       = 2'b01;
    localparam logic [1:0] CODE_GAME_OVER = 2'b10;
    localparam logic [1:0] CODE_START     = 2'b11;

    typedef enum logic [1:0] {IDLE, FIRE, HOLD, GAP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   cnt, cnt_nxt;
    logic [1:0]    code_nxt;
    logic          trigger_nxt;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt;

    logic          full_c;
    logic          flush_c;
    logic          push_c;
    logic          pop_c;
    logic          drop_c;
    logic [1:0]    push_code_c;
    logic [1:0]    head_c;

    assign full_c = (count == CW'(DEPTH));
    assign head_c = mem[rd_ptr];

    // Enqueue arbitration: game-over flushes, otherwise start beats eat
    always_comb begin
        flush_c     = 1'b0;
        push_c      = 1'b0;
        drop_c      = 1'b0;
        push_code_c = CODE_NONE;
        if (evt_game_over) begin
            flush_c = 1'b1;
            drop_c  = evt_start | evt_eat;
        end else if (evt_start) begin
            push_c      = ~full_c;
            push_code_c = CODE_START;
            drop_c      = evt_eat | full_c;
        end else if (evt_eat) begin
            push_c      = ~full_c;
            push_code_c = CODE_EAT;
            drop_c      = full_c;
        end
    end

    // Sequencer next-state and registered-output values
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        code_nxt    = sound_event_code_out;
        trigger_nxt = 1'b0;
        pop_c       = 1'b0;
        case (state)
            IDLE: begin
                code_nxt = CODE_NONE;
                if (count != '0) begin
                    pop_c = 1'b1;
                    if (!mute) begin
                        state_nxt   = FIRE;
                        code_nxt    = head_c;
                        trigger_nxt = 1'b1;
                        case (head_c)
                            CODE_EAT:       cnt_nxt = 32'(DUR_EAT);
                            CODE_GAME_OVER: cnt_nxt = 32'(DUR_GAME_OVER);
                            CODE_START:     cnt_nxt = 32'(DUR_START);
                            default:        cnt_nxt = '0;
                        endcase
                    end
                end
            end
            FIRE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    code_nxt  = CODE_NONE;
                    cnt_nxt   = 32'(GAP_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            GAP: begin
                code_nxt = CODE_NONE;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                code_nxt  = CODE_NONE;
            end
        endcase
    end

    // Queue pointer/occupancy update; a flush wins over any pop in the same cycle
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (flush_c) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = AW'(1);
            count_nxt  = CW'(1);
        end else begin
            if (push_c) wr_ptr_nxt = wr_ptr + AW'(1);
            if (pop_c)  rd_ptr_nxt = rd_ptr + AW'(1);
            count_nxt = count + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (flush_c) begin
            mem[0] <= CODE_GAME_OVER;
        end else if (push_c) begin
            mem[wr_ptr] <= push_code_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            cnt                  <= '0;
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            count                <= '0;
            sound_event_code_out <= CODE_NONE;
            sound_trigger_out    <= 1'b0;
            busy                 <= 1'b0;
            overflow             <= 1'b0;
        end else begin
            state                <= state_nxt;
            cnt                  <= cnt_nxt;
            rd_ptr               <= rd_ptr_nxt;
            wr_ptr               <= wr_ptr_nxt;
            count                <= count_nxt;
            sound_event_code_out <= code_nxt;
            sound_trigger_out    <= trigger_nxt;
            busy                 <= (state_nxt != IDLE) || (count_nxt != '0);
            overflow             <= overflow | drop_c;
        end
    end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Self-checking bench for sound_event_sequencer: scoreboard of expected sounds
// checked against triggers, plus cycle-exact checks of timing, mute and reset.
module tb_sound_event_sequencer;

    localparam int unsigned DUR_EAT       = 5;
    localparam int unsigned DUR_GAME_OVER = 8;
    localparam int unsigned DUR_START     = 6;
    localparam int unsigned GAP_CYCLES    = 3;
    localparam int unsigned DEPTH         = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       evt_eat = 1'b0;
    logic       evt_game_over = 1'b0;
    logic       evt_start = 1'b0;
    logic       mute = 1'b0;
    logic [1:0] sound_event_code_out;
    logic       sound_trigger_out;
    logic       busy;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];
    logic [1:0] cur_code = 2'b00;
    int         run_len = 0;
    int         cyc_no = 0;
    int         last_trig = -1;
    bit         chk_spacing = 1'b0;
    int         spacing_exp = 0;

    sound_event_sequencer #(
        .CLK_FREQ     (1000),
        .DUR_EAT      (DUR_EAT),
        .DUR_GAME_OVER(DUR_GAME_OVER),
        .DUR_START    (DUR_START),
        .GAP_CYCLES   (GAP_CYCLES),
        .DEPTH        (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .evt_eat             (evt_eat),
        .evt_game_over       (evt_game_over),
        .evt_start           (evt_start),
        .mute                (mute),
        .sound_event_code_out(sound_event_code_out),
        .sound_trigger_out   (sound_trigger_out),
        .busy                (busy),
        .overflow            (overflow)
    );

    always #5 clk = ~clk;

    function automatic int code_len(input logic [1:0] c);
        case (c)
            2'b01:   return int'(DUR_EAT) + 2;
            2'b10:   return int'(DUR_GAME_OVER) + 2;
            2'b11:   return int'(DUR_START) + 2;
            default: return 0;
        endcase
    endfunction

    // Scoreboard monitor: every trigger pops an expected code, every sound's length is checked
    always @(negedge clk) begin
        cyc_no++;
        if (!reset_n) begin
            run_len   = 0;
            last_trig = -1;
        end else begin
            if (sound_trigger_out) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_trigger: code=%b, no sound expected", sound_event_code_out);
                    cur_code = sound_event_code_out;
                end else begin
                    cur_code = exp_q.pop_front();
                    if (sound_event_code_out !== cur_code) begin
                        n_fail++;
                        $display("FAIL trigger_code: got %b expected %b", sound_event_code_out, cur_code);
                    end
                end
                if (chk_spacing && last_trig >= 0) begin
                    n_tests++;
                    if (cyc_no - last_trig !== spacing_exp) begin
                        n_fail++;
                        $display("FAIL trigger_spacing: got %0d expected %0d", cyc_no - last_trig, spacing_exp);
                    end
                end
                last_trig = cyc_no;
                run_len   = 0;
            end
            if (sound_event_code_out != 2'b00) begin
                run_len++;
            end else if (run_len > 0) begin
                n_tests++;
                if (run_len !== code_len(cur_code)) begin
                    n_fail++;
                    $display("FAIL hold_length: code %b held %0d expected %0d", cur_code, run_len, code_len(cur_code));
                end
                run_len = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        evt_eat = 1'b0;
        evt_start = 1'b0;
        evt_game_over = 1'b0;
        mute = 1'b0;
        repeat (2) step();
        exp_q.delete();
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_tests++;
        if ({sound_event_code_out, sound_trigger_out, busy, overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got code=%b trig=%b busy=%b ovf=%b expected all 0",
                     sound_event_code_out, sound_trigger_out, busy, overflow);
        end
        do_reset();
        n_tests++;
        if ({sound_event_code_out, sound_trigger_out, busy, overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL after_reset_outputs: got code=%b trig=%b busy=%b ovf=%b expected all 0",
                     sound_event_code_out, sound_trigger_out, busy, overflow);
        end
    endtask

    task automatic test_single_eat();
        logic [1:0] exp_code;
        do_reset();
        evt_eat = 1'b1;
        exp_q.push_back(2'b01);
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == 1) evt_eat = 1'b0;
            exp_code = (c >= 2 && c <= 8) ? 2'b01 : 2'b00;
            n_tests++;
            if (sound_trigger_out !== (c == 2)) begin
                n_fail++;
                $display("FAIL single_trigger c%0d: got %b expected %b", c, sound_trigger_out, (c == 2));
            end
            n_tests++;
            if (sound_event_code_out !== exp_code) begin
                n_fail++;
                $display("FAIL single_code c%0d: got %b expected %b", c, sound_event_code_out, exp_code);
            end
            n_tests++;
            if (busy !== (c < 12)) begin
                n_fail++;
                $display("FAIL single_busy c%0d: got %b expected %b", c, busy, (c < 12));
            end
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_priority();
        do_reset();
        evt_start = 1'b1;
        evt_eat = 1'b1;
        exp_q.push_back(2'b11);
        step();
        evt_start = 1'b0;
        evt_eat = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_overflow: got %b expected 1", overflow);
        end
        wait_idle(60, "priority");
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        last_trig = -1;
        spacing_exp = int'(DUR_EAT) + 2 + int'(GAP_CYCLES) + 1;
        chk_spacing = 1'b1;
        for (int i = 0; i < 6; i++) begin
            evt_eat = 1'b1;
            if (i < 5) exp_q.push_back(2'b01);
            step();
        end
        evt_eat = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overflow: got %b expected 1", overflow);
        end
        wait_idle(200, "b2b");
        chk_spacing = 1'b0;
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_played: %0d sounds missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        evt_eat = 1'b1;
        exp_q.push_back(2'b01);
        step();
        evt_eat = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            evt_eat = 1'b1;
            step();
        end
        evt_eat = 1'b0;
        evt_game_over = 1'b1;
        exp_q.push_back(2'b10);
        step();
        evt_game_over = 1'b0;
        wait_idle(200, "flush");
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_played: %0d sounds missing, expected 0", exp_q.size());
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_mute();
        do_reset();
        mute = 1'b1;
        evt_eat = 1'b1;
        step();
        step();
        evt_eat = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mute_busy: got %b expected 0", busy);
        end
        repeat (6) step();
        mute = 1'b0;
        repeat (4) step();
        n_tests++;
        if (sound_event_code_out !== 2'b00) begin
            n_fail++;
            $display("FAIL mute_code: got %b expected 00", sound_event_code_out);
        end
    endtask

    task automatic test_reset_in_hold();
        int bad_busy;
        do_reset();
        evt_start = 1'b1;
        exp_q.push_back(2'b11);
        step();
        evt_start = 1'b0;
        repeat (4) step();
        n_tests++;
        if (sound_event_code_out !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_code: got %b expected 11", sound_event_code_out);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (sound_event_code_out !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_code: got %b expected 00", sound_event_code_out);
        end
        step();
        reset_n = 1'b1;
        bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0 || sound_trigger_out !== 1'b0) bad_busy++;
        end
        n_tests++;
        if (bad_busy !== 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: %0d active cycles, expected 0", bad_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_eat();
        test_priority();
        test_back_to_back();
        test_flush();
        test_mute();
        test_reset_in_hold();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
